// File: rtl/hdmi_pattern_feeder.sv
// HDMI test-source feeder: selectable video test patterns with frame/line markers,
// plus a multi-channel audio square-wave tone with drop accounting.
module hdmi_pattern_feeder #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned CHECK_LOG2 = 5,
    parameter int unsigned AUD_W      = 16,
    parameter int unsigned AUD_CH     = 2,
    parameter int unsigned AUD_DIV    = 2250,
    parameter int unsigned TONE_HALF  = 24,
    parameter logic [AUD_W-1:0] AMPL  = AUD_W'(16'h2000)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [1:0]              mode,
    input  logic [3*PIX_W-1:0]      solid_color,
    output logic [3*PIX_W-1:0]      video_out,
    output logic                    video_valid,
    input  logic                    video_rdy,
    output logic                    sof,
    output logic                    eol,
    output logic [15:0]             frame_count,
    input  logic                    audio_en,
    output logic signed [AUD_W-1:0] audio_out,
    output logic [2:0]              audio_ch,
    output logic                    audio_valid,
    input  logic                    audio_rdy,
    output logic [7:0]              audio_drop
);

    localparam int unsigned RGB_W = 3 * PIX_W;
    localparam int unsigned X_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned Y_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int unsigned BAR_W = H_ACTIVE / 8;
    localparam int unsigned B_W   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int unsigned T_W   = (AUD_DIV > 1) ? $clog2(AUD_DIV) : 1;
    localparam int unsigned P_W   = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [X_W-1:0]     x, nx;
    logic [Y_W-1:0]     y, ny;
    logic [B_W-1:0]     bar_cnt, nbar_cnt;
    logic [2:0]         bar, nbar;
    logic [1:0]         mode_q;
    logic [RGB_W-1:0]   solid_q;
    logic               last_x, last_y;
    logic [PIX_W-1:0]   nramp;
    logic               nchk;

    logic [T_W-1:0]     tick_cnt;
    logic [P_W-1:0]     half_cnt;
    logic               phase;
    logic               tick;
    logic [2:0]         next_ch;

    function automatic logic [RGB_W-1:0] pattern(input logic [1:0] m, input logic [RGB_W-1:0] solid,
                                                 input logic [PIX_W-1:0] ramp, input logic cxy,
                                                 input logic [2:0] bidx);
        logic [PIX_W-1:0] r, g, b;
        r = bidx[1] ? '0 : '1;
        g = bidx[2] ? '0 : '1;
        b = bidx[0] ? '0 : '1;
        case (m)
            2'd0:    pattern = solid;
            2'd1:    pattern = {r, g, b};
            2'd2:    pattern = {ramp, ramp, ramp};
            default: pattern = cxy ? '1 : '0;
        endcase
    endfunction

    function automatic logic [AUD_W-1:0] sample(input logic ph, input logic odd);
        sample = (ph ^ odd) ? (AUD_W'(0) - AMPL) : AMPL;
    endfunction

    // Position of the pixel that follows the current one; bar index tracked by counter.
    always_comb begin
        last_x   = (x == X_W'(H_ACTIVE - 1));
        last_y   = (y == Y_W'(V_ACTIVE - 1));
        nx       = last_x ? '0 : x + X_W'(1);
        ny       = y;
        nbar_cnt = bar_cnt + B_W'(1);
        nbar     = bar;
        if (last_x) begin
            ny = last_y ? '0 : y + Y_W'(1);
        end
        if (last_x || bar_cnt == B_W'(BAR_W - 1)) begin
            nbar_cnt = '0;
            nbar     = last_x ? 3'd0 : bar + 3'd1;
        end
        nramp = PIX_W'(nx);
        nchk  = 1'(nx >> CHECK_LOG2) ^ 1'(ny >> CHECK_LOG2) ^ frame_count[0];
    end

    assign sof = video_valid && (x == '0) && (y == '0);
    assign eol = video_valid && last_x;

    // Video FSM; mode/colour are only sampled at frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            bar_cnt     <= '0;
            bar         <= '0;
            mode_q      <= '0;
            solid_q     <= '0;
            frame_count <= '0;
            video_out   <= '0;
            video_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state       <= RUN;
                        video_valid <= 1'b1;
                        x           <= '0;
                        y           <= '0;
                        bar_cnt     <= '0;
                        bar         <= '0;
                        mode_q      <= mode;
                        solid_q     <= solid_color;
                        video_out   <= pattern(mode, solid_color, '0, frame_count[0], 3'd0);
                    end
                end
                RUN: begin
                    if (video_rdy) begin
                        x       <= nx;
                        y       <= ny;
                        bar_cnt <= nbar_cnt;
                        bar     <= nbar;
                        if (last_x && last_y) begin
                            frame_count <= frame_count + 16'd1;
                            if (enable) begin
                                mode_q    <= mode;
                                solid_q   <= solid_color;
                                video_out <= pattern(mode, solid_color, '0, ~frame_count[0], 3'd0);
                            end else begin
                                state       <= IDLE;
                                video_valid <= 1'b0;
                                video_out   <= '0;
                            end
                        end else begin
                            video_out <= pattern(mode_q, solid_q, nramp, nchk, nbar);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tick    = audio_en && (tick_cnt == T_W'(AUD_DIV - 1));
    assign next_ch = audio_ch + 3'd1;

    // Audio tone: one sample frame per tick; ticks landing on a pending frame are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt    <= '0;
            half_cnt    <= '0;
            phase       <= 1'b0;
            audio_out   <= '0;
            audio_ch    <= '0;
            audio_valid <= 1'b0;
            audio_drop  <= '0;
        end else begin
            if (!audio_en || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + T_W'(1);
            end
            if (audio_valid) begin
                if (tick && audio_drop != 8'hFF) begin
                    audio_drop <= audio_drop + 8'd1;
                end
                if (audio_rdy) begin
                    if (audio_ch == 3'(AUD_CH - 1)) begin
                        audio_valid <= 1'b0;
                        audio_ch    <= '0;
                        audio_out   <= '0;
                        if (half_cnt == P_W'(TONE_HALF - 1)) begin
                            half_cnt <= '0;
                            phase    <= ~phase;
                        end else begin
                            half_cnt <= half_cnt + P_W'(1);
                        end
                    end else begin
                        audio_ch  <= next_ch;
                        audio_out <= sample(phase, next_ch[0]);
                    end
                end
            end else if (tick) begin
                audio_valid <= 1'b1;
                audio_ch    <= '0;
                audio_out   <= sample(phase, 1'b0);
            end
        end
    end

endmodule
